mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
MEM pipeline stage directly downstream of the execute stage.
- Consumes the EX/MEM register outputs: ALU result, store operand, immediate, NPC+4, 7-bit MEM control word, destination register.
- Performs data-memory loads and stores over a req/gnt/rvalid handshake, with byte/half/word sizing and load sign/zero extension.
- Selects the write-back value and registers it into the MEM/WB pipeline register.
- Raises a stall to freeze upstream stages while an access is outstanding.

Parameters:
N, 32, datapath/address width
RW, 5, destination register index width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
pipe_en  in  1  global pipeline advance enable
ALUres  in  N  EX/MEM ALU result (memory address or arithmetic result)
Bout  in  N  EX/MEM store data
ImmOUT  in  N  EX/MEM immediate (LUI write-back)
NPC4_IN  in  N  EX/MEM PC+4 (JAL/JALR link)
cwMEM  in  7  [6] mem_rd, [5] mem_wr, [4:3] size (00 B, 01 H, 10 W), [2] unsigned, [1:0] wb_sel (00 ALU, 01 MEM, 10 NPC4, 11 IMM)
rf_we_in  in  1  register write enable for this instruction
Rdest_in  in  RW  destination register
dmem_req  out  1  memory request
dmem_we  out  1  1 = store
dmem_addr  out  N  word-aligned address ({ALUres[N-1:2],2'b00})
dmem_be  out  4  byte enables
dmem_wdata  out  N  lane-aligned store data
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  load data valid
dmem_rdata  in  N  load data (full word)
mem_stall  out  1  stall request to upstream
misalign  out  1  registered misaligned-access flag (MEM/WB)
wb_data  out  N  MEM/WB write-back value
wb_Rdest  out  RW  MEM/WB destination register
wb_we  out  1  MEM/WB register write enable
fwd_data  out  N  combinational write-back value for EX forwarding (EXMEMRdest source)

Behaviour:
- Reset (async): FSM to IDLE; dmem_req=0; wb_data, wb_Rdest, wb_we, misalign, internal buffer all 0.
- FSM states: IDLE, WAIT_GNT, WAIT_RV, DONE. Memory op = mem_rd|mem_wr.
- IDLE, memory op present, not misaligned:
  - Drive dmem_req=1.
  - gnt and store: access complete this cycle, mem_stall=0.
  - gnt and load: go to WAIT_RV, mem_stall=1.
  - no gnt: go to WAIT_GNT, mem_stall=1.
- WAIT_GNT: hold req/addr/be/wdata stable until gnt; then apply the same store/load outcomes as IDLE.
- WAIT_RV: dmem_req=0, mem_stall=1. On rvalid: capture the extended data, mem_stall=0.
- Completion cycle:
  - pipe_en=1: MEM/WB captures, go to IDLE.
  - pipe_en=0: store data in internal buffer, go to DONE.
- DONE: no request issued (prevents re-issue of the held instruction), mem_stall=0. When pipe_en=1: MEM/WB captures buffered data, go to IDLE.
- MEM/WB register:
  - Captures when pipe_en=1 and mem_stall=0.
  - While mem_stall=1, wb_we=0 is captured (bubble).
  - Non-memory instructions pass through in 1 cycle.
- Store lanes:
  - B: be=4'b0001<<addr[1:0], wdata replicated x4.
  - H: be=4'b0011<<addr[1:0], wdata replicated x2.
  - W: be=4'b1111.
- Load: rdata shifted right by 8*addr[1:0], then sign- or zero-extended per size/unsigned. size=11 is treated as W.
- wb_sel mux: 00 ALUres, 01 loaded data, 10 NPC4_IN, 11 ImmOUT.
- mem_rd and mem_wr both set: treated as a load.
- dmem_rvalid in IDLE/DONE/WAIT_GNT is ignored. This covers stale responses arriving after a mid-access reset.
- dmem_gnt and dmem_rvalid in the same cycle from IDLE: load completes in that cycle.

Optional Feature:
MEM_MISALIGN_CHECK_EN
- Defined:
  - H with addr[0]=1, or W with addr[1:0]≠0, issues no request.
  - misalign=1 and wb_we=0 are registered with the instruction.
  - No stall.
- Undefined:
  - No check; low address bits are used only for lane selection.
  - misalign tied 0.

Decomposition:
- Shared package mem_pkg:
  - size_e (B/H/W)
  - wb_sel_e
  - mem_state_e
  - cwMEM bit-index constants
  - byte-enable base constants
- One sub-module, lsu_align: combinational store lane/byte-enable generation plus load shift/extend.
- FSM and pipeline registers stay in mem_stage.

Test Plan:
- Word store, addr=0x104, Bout=0xDEADBEEF, gnt same cycle -> req=1, be=1111, wdata=0xDEADBEEF, mem_stall never 1.
- LB addr=0x103, rdata=0x80112233, gnt then rvalid 2 cycles later -> mem_stall high 3 cycles, wb_data=0xFFFFFF80; LBU -> 0x00000080.
- SH addr=0x102, Bout=0x0000ABCD -> be=1100, wdata=0xABCDABCD.
- Load completes with pipe_en=0 for 3 cycles -> DONE, no second req; on pipe_en=1, wb_data=buffered value, wb_we=1.
- Reset asserted in WAIT_RV, late rvalid after release -> req=0, outputs 0, rvalid ignored.
- MEM_MISALIGN_CHECK_EN: LW addr=0x102 -> no req, misalign=1, wb_we=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and control-word field positions for the MEM stage.
// Optional build macro MEM_MISALIGN_CHECK_EN enables the alignment helper below.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_NPC4 = 2'b10,
    WB_IMM  = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_GNT,
    S_WAIT_RV,
    S_DONE
  } mem_state_e;

  localparam int CW_RD    = 6;
  localparam int CW_WR    = 5;
  localparam int CW_SZ_HI = 4;
  localparam int CW_SZ_LO = 3;
  localparam int CW_UNS   = 2;
  localparam int CW_WB_HI = 1;
  localparam int CW_WB_LO = 0;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // size 2'b11 is handled as a word, hence the test on size[1]
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_H) && off[0]) || (size[1] && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/gnt/rvalid bus between the MEM stage (master) and memory (slave).
// Request fields stay stable from req until gnt; rdata is sampled only with rvalid.
interface mem_stage_if #(
  parameter int N = 32
);
  logic         req;
  logic         we;
  logic [N-1:0] addr;
  logic [3:0]   be;
  logic [N-1:0] wdata;
  logic         gnt;
  logic         rvalid;
  logic [N-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// Store lane replication / byte enables and load shift + sign/zero extension; zero latency.
// Purely combinational, no backpressure.
module lsu_align
  import mem_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [1:0]   off,
  input  logic [1:0]   size,
  input  logic         uns,
  input  logic [N-1:0] st_data,
  input  logic [N-1:0] rdata,
  output logic [3:0]   be,
  output logic [N-1:0] wdata,
  output logic [N-1:0] ld_data
);

  logic [N-1:0] ld_sh;

  always_comb begin
    ld_sh   = rdata >> {off, 3'b000};
    be      = BE_W;
    wdata   = st_data;
    ld_data = ld_sh;
    case (size)
      SZ_B: begin
        be      = BE_B << off;
        wdata   = {(N/8){st_data[7:0]}};
        ld_data = uns ? {{(N-8){1'b0}}, ld_sh[7:0]} : {{(N-8){ld_sh[7]}}, ld_sh[7:0]};
      end
      SZ_H: begin
        be      = BE_H << off;
        wdata   = {(N/16){st_data[15:0]}};
        ld_data = uns ? {{(N-16){1'b0}}, ld_sh[15:0]} : {{(N-16){ld_sh[15]}}, ld_sh[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory access FSM plus MEM/WB register; non-memory ops 1 cycle, memory ops until gnt/rvalid.
// mem_stall freezes upstream while an access is open; MEM_MISALIGN_CHECK_EN drops misaligned H/W accesses.
module mem_stage
  import mem_pkg::*;
#(
  parameter int N  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_en,
  input  logic [N-1:0]  ALUres,
  input  logic [N-1:0]  Bout,
  input  logic [N-1:0]  ImmOUT,
  input  logic [N-1:0]  NPC4_IN,
  input  logic [6:0]    cwMEM,
  input  logic          rf_we_in,
  input  logic [RW-1:0] Rdest_in,
  mem_stage_if.master   dmem,
  output logic          mem_stall,
  output logic          misalign,
  output logic [N-1:0]  wb_data,
  output logic [RW-1:0] wb_Rdest,
  output logic          wb_we,
  output logic [N-1:0]  fwd_data
);

  mem_state_e    state_q, state_d;
  logic [N-1:0]  buf_q, buf_d;
  logic [N-1:0]  wb_data_q, wb_data_d;
  logic [RW-1:0] wb_rdest_q, wb_rdest_d;
  logic          wb_we_q, wb_we_d;
  logic          misal_q, misal_d;

  logic          mem_rd, mem_wr, is_load, mem_op, uns, misal, done;
  logic [1:0]    size, wb_sel;
  logic [N-1:0]  ld_ext, load_val, wb_val;

  assign mem_rd  = cwMEM[CW_RD];
  assign mem_wr  = cwMEM[CW_WR];
  assign size    = cwMEM[CW_SZ_HI:CW_SZ_LO];
  assign uns     = cwMEM[CW_UNS];
  assign wb_sel  = cwMEM[CW_WB_HI:CW_WB_LO];
  assign is_load = mem_rd;
  assign mem_op  = mem_rd | mem_wr;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misal = mem_op && is_misaligned(size, ALUres[1:0]);
`else
  assign misal = 1'b0;
`endif

  lsu_align #(.N(N)) u_lsu_align (
    .off     (ALUres[1:0]),
    .size    (size),
    .uns     (uns),
    .st_data (Bout),
    .rdata   (dmem.rdata),
    .be      (dmem.be),
    .wdata   (dmem.wdata),
    .ld_data (ld_ext)
  );

  assign dmem.addr = {ALUres[N-1:2], 2'b00};
  assign dmem.we   = mem_wr & ~mem_rd;

  always_comb begin
    state_d   = state_q;
    dmem.req  = 1'b0;
    mem_stall = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_op && !misal) begin
          dmem.req = 1'b1;
          if (!dmem.gnt) begin
            state_d   = S_WAIT_GNT;
            mem_stall = 1'b1;
          end else if (!is_load || dmem.rvalid) begin
            done = 1'b1;
          end else begin
            state_d   = S_WAIT_RV;
            mem_stall = 1'b1;
          end
        end
      end
      S_WAIT_GNT: begin
        dmem.req = 1'b1;
        if (!dmem.gnt) begin
          mem_stall = 1'b1;
        end else if (!is_load) begin
          done = 1'b1;
        end else begin
          state_d   = S_WAIT_RV;
          mem_stall = 1'b1;
        end
      end
      S_WAIT_RV: begin
        if (dmem.rvalid) done = 1'b1;
        else             mem_stall = 1'b1;
      end
      S_DONE: begin
        if (pipe_en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A finished access that cannot retire parks in DONE so it is never re-issued
    if (done) state_d = pipe_en ? S_IDLE : S_DONE;
  end

  always_comb begin
    load_val = (state_q == S_DONE) ? buf_q : ld_ext;
    case (wb_sel)
      WB_ALU:  wb_val = ALUres;
      WB_MEM:  wb_val = load_val;
      WB_NPC4: wb_val = NPC4_IN;
      default: wb_val = ImmOUT;
    endcase
  end

  assign fwd_data = wb_val;

  always_comb begin
    buf_d      = (done && !pipe_en) ? ld_ext : buf_q;
    wb_data_d  = wb_data_q;
    wb_rdest_d = wb_rdest_q;
    wb_we_d    = wb_we_q;
    misal_d    = misal_q;
    if (mem_stall) begin
      wb_we_d = 1'b0;
      misal_d = 1'b0;
    end else if (pipe_en) begin
      wb_data_d  = wb_val;
      wb_rdest_d = Rdest_in;
      wb_we_d    = rf_we_in & ~misal;
      misal_d    = misal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      wb_data_q  <= '0;
      wb_rdest_q <= '0;
      wb_we_q    <= 1'b0;
      misal_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      wb_data_q  <= wb_data_d;
      wb_rdest_q <= wb_rdest_d;
      wb_we_q    <= wb_we_d;
      misal_q    <= misal_d;
    end
  end

  assign wb_data  = wb_data_q;
  assign wb_Rdest = wb_rdest_q;
  assign wb_we    = wb_we_q;
  assign misalign = misal_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table plus multi-cycle handshake sequences.
module tb_mem_stage;
  import mem_pkg::*;

  localparam int N  = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_en;
  logic [N-1:0]  alu_res, b_out, imm_out, npc4;
  logic [6:0]    cw;
  logic          rf_we;
  logic [RW-1:0] rd;
  logic          mem_stall, misalign, wb_we;
  logic [N-1:0]  wb_data, fwd_data;
  logic [RW-1:0] wb_rdest;

  always #5 clk = ~clk;

  mem_stage_if #(.N(N)) dmem ();

  mem_stage #(.N(N), .RW(RW)) dut (
    .clk      (clk),
    .rst      (rst),
    .pipe_en  (pipe_en),
    .ALUres   (alu_res),
    .Bout     (b_out),
    .ImmOUT   (imm_out),
    .NPC4_IN  (npc4),
    .cwMEM    (cw),
    .rf_we_in (rf_we),
    .Rdest_in (rd),
    .dmem     (dmem.master),
    .mem_stall(mem_stall),
    .misalign (misalign),
    .wb_data  (wb_data),
    .wb_Rdest (wb_rdest),
    .wb_we    (wb_we),
    .fwd_data (fwd_data)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [6:0]  cw;
    logic [31:0] alu;
    logic [31:0] bout;
    logic [31:0] rdata;
    logic        rfwe;
    logic [4:0]  rd;
    logic        bus;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] wb;
    logic        wbwe;
  } vec_t;

  localparam int NV = 14;
  vec_t v [NV];

  // Load with no gnt on first cycle, gnt next, rvalid two cycles after gnt
  task automatic run_lb(input logic [6:0] c, input logic [31:0] exp, input string nm);
    int stalls = 0;
    @(negedge clk);
    cw = c; alu_res = 32'h103; b_out = 0; rf_we = 1; rd = 5'd20; pipe_en = 1;
    dmem.gnt = 0; dmem.rvalid = 0; dmem.rdata = 32'h80112233;
    #1; chk({nm, ".req0"}, dmem.req, 1'b1); stalls += int'(mem_stall);
    @(posedge clk); #1; chk({nm, ".bubble"}, wb_we, 1'b0);
    @(negedge clk); dmem.gnt = 1;
    #1; chk({nm, ".req1"}, dmem.req, 1'b1); stalls += int'(mem_stall);
    @(posedge clk); #1;
    @(negedge clk); dmem.gnt = 0;
    #1; chk({nm, ".req_rv"}, dmem.req, 1'b0); stalls += int'(mem_stall);
    @(posedge clk); #1;
    @(negedge clk); dmem.rvalid = 1;
    #1; stalls += int'(mem_stall); chk({nm, ".fwd"}, fwd_data, exp);
    @(posedge clk); #1;
    chk({nm, ".stall_cycles"}, stalls, 3);
    chk({nm, ".wb_data"}, wb_data, exp);
    chk({nm, ".wb_we"}, wb_we, 1'b1);
    chk({nm, ".wb_rdest"}, wb_rdest, 5'd20);
    @(negedge clk); cw = 0; dmem.rvalid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    v[0]  = '{7'h00, 32'h12345678, 32'h0,        32'h0,        1'b1, 5'd1,  1'b0, 4'h0, 32'h0,        1'b0, 32'h12345678, 1'b1};
    v[1]  = '{7'h02, 32'h0,        32'h0,        32'h0,        1'b1, 5'd2,  1'b0, 4'h0, 32'h0,        1'b0, 32'h00000104, 1'b1};
    v[2]  = '{7'h03, 32'h0,        32'h0,        32'h0,        1'b1, 5'd3,  1'b0, 4'h0, 32'h0,        1'b0, 32'hABCDE000, 1'b1};
    v[3]  = '{7'h30, 32'h104,      32'hDEADBEEF, 32'h0,        1'b0, 5'd0,  1'b1, 4'hF, 32'hDEADBEEF, 1'b1, 32'h00000104, 1'b0};
    v[4]  = '{7'h28, 32'h102,      32'h0000ABCD, 32'h0,        1'b0, 5'd0,  1'b1, 4'hC, 32'hABCDABCD, 1'b1, 32'h00000102, 1'b0};
    v[5]  = '{7'h20, 32'h101,      32'h000000EE, 32'h0,        1'b0, 5'd0,  1'b1, 4'h2, 32'hEEEEEEEE, 1'b1, 32'h00000101, 1'b0};
    v[6]  = '{7'h41, 32'h103,      32'h0,        32'h80112233, 1'b1, 5'd6,  1'b1, 4'h8, 32'h0,        1'b0, 32'hFFFFFF80, 1'b1};
    v[7]  = '{7'h45, 32'h103,      32'h0,        32'h80112233, 1'b1, 5'd7,  1'b1, 4'h8, 32'h0,        1'b0, 32'h00000080, 1'b1};
    v[8]  = '{7'h49, 32'h102,      32'h0,        32'h80112233, 1'b1, 5'd8,  1'b1, 4'hC, 32'h0,        1'b0, 32'hFFFF8011, 1'b1};
    v[9]  = '{7'h4D, 32'h102,      32'h0,        32'h80112233, 1'b1, 5'd9,  1'b1, 4'hC, 32'h0,        1'b0, 32'h00008011, 1'b1};
    v[10] = '{7'h51, 32'h100,      32'h0,        32'h80112233, 1'b1, 5'd10, 1'b1, 4'hF, 32'h0,        1'b0, 32'h80112233, 1'b1};
    v[11] = '{7'h41, 32'h101,      32'h0,        32'h80112233, 1'b1, 5'd11, 1'b1, 4'h2, 32'h0,        1'b0, 32'h00000022, 1'b1};
    v[12] = '{7'h71, 32'h100,      32'h0,        32'h00005555, 1'b1, 5'd12, 1'b1, 4'hF, 32'h0,        1'b0, 32'h00005555, 1'b1};
    v[13] = '{7'h59, 32'h108,      32'h0,        32'hCAFEF00D, 1'b1, 5'd13, 1'b1, 4'hF, 32'h0,        1'b0, 32'hCAFEF00D, 1'b1};

    rst = 1; pipe_en = 0; alu_res = 0; b_out = 0; imm_out = 32'hABCDE000; npc4 = 32'h104;
    cw = 0; rf_we = 0; rd = 0; dmem.gnt = 0; dmem.rvalid = 0; dmem.rdata = 0;
    @(posedge clk); #1;
    chk("rst.req", dmem.req, 1'b0);
    chk("rst.stall", mem_stall, 1'b0);
    chk("rst.wb_data", wb_data, 32'h0);
    chk("rst.wb_we", wb_we, 1'b0);
    chk("rst.wb_rdest", wb_rdest, 5'd0);
    chk("rst.misalign", misalign, 1'b0);
    @(negedge clk); rst = 0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      cw = v[i].cw; alu_res = v[i].alu; b_out = v[i].bout; rf_we = v[i].rfwe; rd = v[i].rd;
      pipe_en = 1; dmem.gnt = 1; dmem.rvalid = 1; dmem.rdata = v[i].rdata;
      #1;
      chk($sformatf("v%0d.req", i), dmem.req, v[i].bus);
      chk($sformatf("v%0d.stall", i), mem_stall, 1'b0);
      chk($sformatf("v%0d.fwd", i), fwd_data, v[i].wb);
      if (v[i].bus) begin
        chk($sformatf("v%0d.be", i), dmem.be, v[i].be);
        chk($sformatf("v%0d.wdata", i), dmem.wdata, v[i].wdata);
        chk($sformatf("v%0d.we", i), dmem.we, v[i].we);
        chk($sformatf("v%0d.addr", i), dmem.addr, {v[i].alu[31:2], 2'b00});
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d.wb_data", i), wb_data, v[i].wb);
      chk($sformatf("v%0d.wb_we", i), wb_we, v[i].wbwe);
      chk($sformatf("v%0d.wb_rdest", i), wb_rdest, v[i].rd);
    end

    run_lb(7'h41, 32'hFFFFFF80, "lb_seq");
    run_lb(7'h45, 32'h00000080, "lbu_seq");

    // Store waits two cycles for gnt with request held stable
    @(negedge clk);
    cw = 7'h30; alu_res = 32'h10C; b_out = 32'h11223344; rf_we = 0; rd = 0; pipe_en = 1;
    dmem.gnt = 0; dmem.rvalid = 0;
    #1; chk("sw_wait.req0", dmem.req, 1'b1); chk("sw_wait.stall0", mem_stall, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    #1; chk("sw_wait.req1", dmem.req, 1'b1); chk("sw_wait.addr", dmem.addr, 32'h10C);
    chk("sw_wait.wdata", dmem.wdata, 32'h11223344); chk("sw_wait.stall1", mem_stall, 1'b1);
    @(posedge clk); #1;
    @(negedge clk); dmem.gnt = 1;
    #1; chk("sw_wait.stall_gnt", mem_stall, 1'b0);
    @(posedge clk); #1; chk("sw_wait.wb_data", wb_data, 32'h10C);
    @(negedge clk); cw = 0; dmem.gnt = 0; rf_we = 1;
    #1; chk("sw_wait.req_after", dmem.req, 1'b0);
    @(posedge clk); #1;

    // Load completes while pipe_en is low, parks in DONE
    @(negedge clk);
    cw = 7'h51; alu_res = 32'h100; rf_we = 1; rd = 5'd21; pipe_en = 0;
    dmem.gnt = 1; dmem.rvalid = 0; dmem.rdata = 32'h13572468;
    #1; chk("done.stall0", mem_stall, 1'b1);
    @(posedge clk); #1;
    @(negedge clk); dmem.gnt = 0; dmem.rvalid = 1;
    #1; chk("done.stall_rv", mem_stall, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); dmem.rvalid = 0; dmem.rdata = 32'h0; dmem.gnt = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("done.req%0d", k), dmem.req, 1'b0);
      chk($sformatf("done.stall%0d", k + 1), mem_stall, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("done.wb_we_hold%0d", k), wb_we, 1'b0);
      @(negedge clk);
    end
    pipe_en = 1;
    #1; chk("done.fwd", fwd_data, 32'h13572468);
    @(posedge clk); #1;
    chk("done.wb_data", wb_data, 32'h13572468);
    chk("done.wb_we", wb_we, 1'b1);
    chk("done.wb_rdest", wb_rdest, 5'd21);
    @(negedge clk); cw = 0; dmem.gnt = 0;
    #1; chk("done.req_idle", dmem.req, 1'b0);
    @(posedge clk); #1;

    // Reset while waiting for rvalid, then a stale rvalid arrives
    @(negedge clk);
    cw = 7'h51; alu_res = 32'h200; rf_we = 1; rd = 5'd22; pipe_en = 1;
    dmem.gnt = 1; dmem.rvalid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1; cw = 0; alu_res = 0; rf_we = 0; rd = 0; dmem.gnt = 0;
    #1;
    chk("arst.req", dmem.req, 1'b0);
    chk("arst.wb_data", wb_data, 32'h0);
    chk("arst.wb_we", wb_we, 1'b0);
    chk("arst.wb_rdest", wb_rdest, 5'd0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    @(negedge clk); dmem.rvalid = 1; dmem.rdata = 32'hDEADBEEF;
    #1;
    chk("stale.req", dmem.req, 1'b0);
    chk("stale.stall", mem_stall, 1'b0);
    chk("stale.fwd", fwd_data, 32'h0);
    @(posedge clk); #1;
    chk("stale.wb_we", wb_we, 1'b0);
    chk("stale.wb_data", wb_data, 32'h0);
    @(negedge clk); dmem.rvalid = 0; alu_res = 32'h55; rf_we = 1; rd = 5'd3;
    @(posedge clk); #1;
    chk("post_rst.wb_data", wb_data, 32'h55);
    chk("post_rst.wb_we", wb_we, 1'b1);

`ifdef MEM_MISALIGN_CHECK_EN
    @(negedge clk);
    cw = 7'h51; alu_res = 32'h102; rf_we = 1; rd = 5'd4; dmem.gnt = 1;
    #1; chk("mis.req", dmem.req, 1'b0); chk("mis.stall", mem_stall, 1'b0);
    @(posedge clk); #1;
    chk("mis.flag", misalign, 1'b1);
    chk("mis.wb_we", wb_we, 1'b0);
    @(negedge clk); cw = 0; dmem.gnt = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
